uart_rcv_fifo: RTL



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rcv_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and default baud divisor, shared by the UART receiver
// and the future parametrised transmitter.
package uart_pkg;

    // 50 MHz system clock / 19200 baud
    localparam int BAUD_DIV_DEFAULT = 2604;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with show-ahead read, full/empty flags and an explicit
// entry count. A write while full is accepted only if a read happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || rd_en);

    // Forced to zero while empty so the head reads as 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count need one, and leaving
    // the array unreset lets it map onto plain RAM/registers without reset wiring.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rcv_fifo.sv
// uart_rcv_fifo: mid-bit sampling UART receiver with sticky error flags feeding a receive FIFO.
// Define UART_RCV_PARITY_EN to add a parity bit, the ODD_PARITY parameter and parity_err.
module uart_rcv_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 8
`ifdef UART_RCV_PARITY_EN
    ,
    parameter bit ODD_PARITY = 1'b0
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RX,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rdy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          clr_err,
    output logic                          framing_err,
    output logic                          overrun_err
`ifdef UART_RCV_PARITY_EN
    ,
    output logic                          parity_err
`endif
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

    rx_state_t            state_q, state_d;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]     baud_cnt, cnt_val;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_q, push_data;
    logic                 push_q, fifo_empty;
    logic                 start_edge, tick, cnt_load, sample_bit, frame_end;
    logic                 parity_good, framing_set, overrun_set;

    // Edge detector is re-armed at the end of each frame, so a line held low (break)
    // starts a new frame and reports a framing error once per frame time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= frame_end ? 1'b1 : rx_sync;
        end
    end

    assign start_edge = rx_prev && !rx_sync;
    assign tick       = (baud_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_val    = FULL_LOAD;
        sample_bit = 1'b0;
        frame_end  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d  = START;
                    cnt_load = 1'b1;
                    cnt_val  = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_sync) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        cnt_load = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sample_bit = 1'b1;
                    cnt_load   = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RCV_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RCV_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d  = STOP;
                    cnt_load = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    frame_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            if (cnt_load)             baud_cnt <= cnt_val;
            else if (baud_cnt != '0)  baud_cnt <= baud_cnt - 1'b1;

            if (state_q == IDLE)      bit_cnt <= '0;
            else if (sample_bit)      bit_cnt <= bit_cnt + 1'b1;

            if (sample_bit)           shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RCV_PARITY_EN
    logic par_bit_q;
    logic parity_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          par_bit_q <= 1'b0;
        else if (state_q == PARITY && tick)  par_bit_q <= rx_sync;
    end

    assign parity_good = ((^shift_q) ^ par_bit_q) == ODD_PARITY;
    assign parity_set  = frame_end && rx_sync && !parity_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          parity_err <= 1'b0;
        else if (parity_set) parity_err <= 1'b1;
        else if (clr_err)    parity_err <= 1'b0;
    end
`else
    assign parity_good = 1'b1;
`endif

    assign framing_set = frame_end && !rx_sync;
    assign overrun_set = push_q && full && !rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q      <= 1'b0;
            push_data   <= '0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            push_q    <= frame_end && rx_sync && parity_good;
            push_data <= shift_q;

            if (framing_set)      framing_err <= 1'b1;
            else if (clr_err)     framing_err <= 1'b0;

            if (overrun_set)      overrun_err <= 1'b1;
            else if (clr_err)     overrun_err <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_q),
        .wr_data (push_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign rdy = !fifo_empty;

endmodule
